button_debouncer: RTL and testbench
===================================

# button_debouncer

Parametrised multi-channel debouncer for the board push-buttons feeding the game logic (paddle up/down, serve, reset-game). Each channel is synchronised and sampled on a shared slow tick. A channel changes its debounced level only after STABLE_SAMPLES consecutive identical samples. Per channel the block emits level, press/release edge pulses, and an auto-repeat step pulse for held buttons, so paddle movement needs no extra counting logic downstream.

## Interface
Parameters:
- CHANNELS, 4, number of independent button inputs (>=1)
- TICK_DIV, 60000, i_clk cycles per sample tick (>=1; 1 = tick every cycle)
- STABLE_SAMPLES, 2, consecutive differing samples required to change level (>=1)
- REPEAT_DELAY, 0, ticks from press to first repeat step; 0 disables auto-repeat
- REPEAT_RATE, 1, ticks between subsequent repeat steps (>=1)

Ports:
- i_clk  input  1  system clock; one clock domain
- i_rst  input  1  reset, asynchronous, active-high
- i_buttons  input  CHANNELS  raw asynchronous button levels, 1 = pressed
- o_level  output  CHANNELS  debounced level
- o_press  output  CHANNELS  one-cycle pulse on debounced 0->1
- o_release  output  CHANNELS  one-cycle pulse on debounced 1->0
- o_step  output  CHANNELS  one-cycle pulse on press and on each auto-repeat

## Operation
- Reset (async, immediate, no clock needed): all outputs 0, synchroniser flops 0, prescaler 0, all per-channel counters 0, all repeat FSMs IDLE.
- Synchroniser: two flops per channel; sampled value s[n] = second flop.
- Prescaler: counter 0..TICK_DIV-1, wraps to 0; tick high for the single cycle in which counter == TICK_DIV-1. Width $clog2(TICK_DIV), min 1.
- Stability counter per channel (width $clog2(STABLE_SAMPLES+1)), updated only on tick:
  - s[n] == o_level[n]: counter <= 0.
  - s[n] != o_level[n] and counter+1 < STABLE_SAMPLES: counter <= counter+1.
  - s[n] != o_level[n] and counter+1 == STABLE_SAMPLES: o_level[n] <= s[n], counter <= 0, pulse o_press or o_release accordingly.
- Channels fully independent; any mix of channels may change on the same tick.
- Repeat FSM per channel, states IDLE, DELAY, REPEAT; repeat counter wide enough for max(REPEAT_DELAY, REPEAT_RATE):
  - IDLE: on press, o_step pulses with o_press; go DELAY with rcnt 0 if REPEAT_DELAY>0, else stay IDLE.
  - DELAY: each tick rcnt++; when rcnt reaches REPEAT_DELAY: o_step pulse, rcnt 0, go REPEAT.
  - REPEAT: each tick rcnt++; when rcnt reaches REPEAT_RATE: o_step pulse, rcnt 0.
  - Release (any state): go IDLE, rcnt 0, no o_step. Release takes priority over a repeat due on the same tick.
  - Press tick itself does not advance rcnt.

## Timing
- All outputs registered; no combinational path from i_buttons.
- o_level[n], o_press/o_release[n] and o_step[n] change on the clock edge that ends the tick cycle. Pulses are high for exactly one cycle, which is the first cycle the new level is visible.
- Latency from a clean input edge to o_level: 2 cycles of synchronisation plus STABLE_SAMPLES ticks. The bound is at most 2 + STABLE_SAMPLES*TICK_DIV + 1 cycles.
- A disturbance that covers fewer than STABLE_SAMPLES consecutive ticks never changes o_level.
- Repeat steps while held: press, press + REPEAT_DELAY ticks, then every REPEAT_RATE ticks.
- Reset asserted mid-operation clears state instantly. After deassertion, a held button needs a full STABLE_SAMPLES ticks before o_press.

## Test plan
Bench parameters: CHANNELS=4, TICK_DIV=4, STABLE_SAMPLES=3, REPEAT_DELAY=5, REPEAT_RATE=2.
- Clean press: i_buttons[0] 0->1 and held. Required: o_level[0]=1 within 15 cycles. o_press[0] and o_step[0] high for that same single cycle. Other channels stay 0.
- Bounce rejection: i_buttons[1] high 5 cycles / low 8 cycles, repeated 10 times. Required: o_level[1] stays 0, no pulses. Input then held high: o_press[1] within 15 cycles.
- Auto-repeat: hold ch0 after press. Required: o_step[0] at press, at press+20 cycles, then every 8 cycles. On release: o_release[0] once and no further o_step.
- Simultaneous events: ch2 released-to-pressed and ch3 pressed-to-released on the same cycle. Required: o_press[2] and o_release[3] in the same cycle.
- Release glitch: ch0 held with o_level=1; input low for 8 cycles (2 ticks), then high. Required: no o_release, repeat cadence unchanged.
- Async reset mid-hold: assert i_rst between clock edges during a repeat. Required: all outputs 0 before the next edge. After deassertion with the button still held, o_press[0] recurs only after 3 ticks.

Source files
------------

// File: rtl/button_debouncer.sv
// Purpose : multi-channel push-button debouncer with press/release edges and auto-repeat steps.
// Latency : 2 sync cycles + STABLE_SAMPLES sample ticks from a clean input edge to o_level/o_press.
// Backpr. : none; outputs are free-running levels and single-cycle pulses, nothing is held off.
//
// Ports:
//   i_clk      system clock (single domain)
//   i_rst      asynchronous active-high reset
//   i_buttons  raw asynchronous button levels, 1 = pressed
//   o_level    debounced level per channel
//   o_press    one-cycle pulse on debounced 0->1
//   o_release  one-cycle pulse on debounced 1->0
//   o_step     one-cycle pulse on press and on every auto-repeat while held
module button_debouncer #(
    parameter int CHANNELS       = 4,
    parameter int TICK_DIV       = 60000,
    parameter int STABLE_SAMPLES = 2,
    parameter int REPEAT_DELAY   = 0,
    parameter int REPEAT_RATE    = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [CHANNELS-1:0] i_buttons,
    output logic [CHANNELS-1:0] o_level,
    output logic [CHANNELS-1:0] o_press,
    output logic [CHANNELS-1:0] o_release,
    output logic [CHANNELS-1:0] o_step
);

    // ------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW   = $clog2(STABLE_SAMPLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX + 1) : 1;

    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] STABLE_N  = CW'(STABLE_SAMPLES);
    localparam logic [RW-1:0] DELAY_N   = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RATE_N    = RW'(REPEAT_RATE);
    // A zero delay means a press produces only the initial step.
    localparam bit            REPEAT_EN = (REPEAT_DELAY > 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    // ------------------------------------------------------------------
    // Two-flop synchroniser per channel
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] sync_meta;
    logic [CHANNELS-1:0] sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= i_buttons;
            sync_q    <= sync_meta;
        end
    end

    // ------------------------------------------------------------------
    // Shared sample prescaler; tick is high for the last count only
    // ------------------------------------------------------------------
    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == TICK_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------
    logic [CW-1:0] scnt     [CHANNELS];
    logic [CW-1:0] scnt_inc [CHANNELS];
    logic [RW-1:0] rcnt     [CHANNELS];
    logic [RW-1:0] rcnt_inc [CHANNELS];
    rpt_state_t    rstate   [CHANNELS];

    logic [CHANNELS-1:0] differ;   // synchronised sample disagrees with debounced level
    logic [CHANNELS-1:0] commit;   // this tick completes the required run of samples
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;

    always_comb begin
        differ = '0;
        commit = '0;
        rise   = '0;
        fall   = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            scnt_inc[ch] = scnt[ch] + 1'b1;
            rcnt_inc[ch] = rcnt[ch] + 1'b1;
            differ[ch]   = (sync_q[ch] != o_level[ch]);
            commit[ch]   = tick && differ[ch] && (scnt_inc[ch] == STABLE_N);
            rise[ch]     = commit[ch] &&  sync_q[ch];
            fall[ch]     = commit[ch] && !sync_q[ch];
        end
    end

    // Stability counters, debounced levels, edge pulses and repeat FSMs.
    // Everything is registered, so no path exists from i_buttons to outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_level   <= '0;
            o_press   <= '0;
            o_release <= '0;
            o_step    <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                scnt[ch]   <= '0;
                rcnt[ch]   <= '0;
                rstate[ch] <= ST_IDLE;
            end
        end else begin
            o_press   <= rise;
            o_release <= fall;

            for (int ch = 0; ch < CHANNELS; ch++) begin
                // Stability counter: any sample matching the current level
                // restarts the run, so short disturbances are discarded.
                if (tick) begin
                    if (!differ[ch]) begin
                        scnt[ch] <= '0;
                    end else if (commit[ch]) begin
                        o_level[ch] <= sync_q[ch];
                        scnt[ch]    <= '0;
                    end else begin
                        scnt[ch] <= scnt_inc[ch];
                    end
                end

                // Repeat FSM. Release wins over a step that falls due on the
                // same tick; the press tick itself does not advance rcnt.
                o_step[ch] <= 1'b0;
                if (fall[ch]) begin
                    rstate[ch] <= ST_IDLE;
                    rcnt[ch]   <= '0;
                end else if (rise[ch]) begin
                    o_step[ch] <= 1'b1;
                    rcnt[ch]   <= '0;
                    rstate[ch] <= REPEAT_EN ? ST_DELAY : ST_IDLE;
                end else if (tick) begin
                    case (rstate[ch])
                        ST_DELAY: begin
                            if (rcnt_inc[ch] == DELAY_N) begin
                                o_step[ch] <= 1'b1;
                                rcnt[ch]   <= '0;
                                rstate[ch] <= ST_REPEAT;
                            end else begin
                                rcnt[ch] <= rcnt_inc[ch];
                            end
                        end
                        ST_REPEAT: begin
                            if (rcnt_inc[ch] == RATE_N) begin
                                o_step[ch] <= 1'b1;
                                rcnt[ch]   <= '0;
                            end else begin
                                rcnt[ch] <= rcnt_inc[ch];
                            end
                        end
                        default: begin
                            rcnt[ch]   <= '0;
                            rstate[ch] <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Purpose : directed bench for button_debouncer (4 channels, TICK_DIV=4, 3 samples, delay 5, rate 2).
// Latency : expected values are cycle-exact, counted in clock edges after reset release.
// Backpr. : not applicable; the bench drives inputs freely and samples 1 time unit after each edge.
module tb_button_debouncer;

    logic       i_clk;
    logic       i_rst;
    logic [3:0] i_buttons;
    logic [3:0] o_level;
    logic [3:0] o_press;
    logic [3:0] o_release;
    logic [3:0] o_step;

    button_debouncer #(
        .CHANNELS      (4),
        .TICK_DIV      (4),
        .STABLE_SAMPLES(3),
        .REPEAT_DELAY  (5),
        .REPEAT_RATE   (2)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_buttons(i_buttons),
        .o_level  (o_level),
        .o_press  (o_press),
        .o_release(o_release),
        .o_step   (o_step)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int       cyc;   // edge count at which to compare, then drive btn
        logic [3:0] btn;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] stp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int c, input logic [3:0] b, input logic [3:0] l,
                       input logic [3:0] p, input logic [3:0] r, input logic [3:0] s);
        vec_t v;
        v.cyc = c; v.btn = b; v.lvl = l; v.prs = p; v.rel = r; v.stp = s;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

    logic quiet;
    logic found;

    initial begin
        i_rst     = 1'b1;
        i_buttons = 4'b0000;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        cyc   = 0;

        // Ticks are consumed on edges 4, 8, 12, ...; an input driven after
        // edge j is first seen by the tick at edge >= j+3.
        //   cyc  btn      lvl      prs      rel      stp
        add(  0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // reset state, press ch0
        add( 11, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add( 12, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001); // level, press, step together
        add( 13, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add( 31, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add( 32, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001); // press + 20 cycles
        add( 33, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add( 40, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001); // then every 8
        add( 47, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add( 48, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        add( 49, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000); // glitch low, 2 ticks
        add( 56, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        add( 57, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000); // back high
        add( 60, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000); // no release
        add( 64, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001); // cadence unchanged
        add( 72, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        add( 75, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000); // real release
        add( 80, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        add( 87, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add( 88, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000); // release beats due step
        add( 89, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add( 96, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(104, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            while (cyc < vecs[i].cyc) step();
            chk($sformatf("vec%0d", i),
                {o_level, o_press, o_release, o_step},
                {vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].stp});
            i_buttons = vecs[i].btn;
        end

        // Bounce on ch1: 5 cycles high never spans 3 ticks.
        quiet = 1'b1;
        for (int r = 0; r < 10; r++) begin
            i_buttons[1] = 1'b1;
            repeat (5) begin
                step();
                if (o_level[1] | o_press[1] | o_release[1] | o_step[1]) quiet = 1'b0;
            end
            i_buttons[1] = 1'b0;
            repeat (8) begin
                step();
                if (o_level[1] | o_press[1] | o_release[1] | o_step[1]) quiet = 1'b0;
            end
        end
        chk("bounce_quiet", {15'd0, quiet}, 16'd1);

        i_buttons[1] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 15 && !found; i++) begin
            step();
            if (o_press[1]) found = 1'b1;
        end
        chk("bounce_hold_press", {15'd0, found}, 16'd1);
        chk("bounce_hold_outs", {o_level, o_step}, {4'b0010, 4'b0010});

        i_buttons[1] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (o_release[1]) found = 1'b1;
        end
        chk("ch1_release", {15'd0, found}, 16'd1);

        // Simultaneous: ch3 up first, then ch2 up and ch3 down on one cycle.
        i_buttons[3] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 15 && !found; i++) begin
            step();
            if (o_press[3]) found = 1'b1;
        end
        chk("ch3_press", {15'd0, found}, 16'd1);

        i_buttons[2] = 1'b1;
        i_buttons[3] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 15 && !found; i++) begin
            step();
            if (o_press[2] | o_release[3]) found = 1'b1;
        end
        chk("simul_pulses", {o_press, o_release}, {4'b0100, 4'b1000});
        chk("simul_level", {12'd0, o_level}, {12'd0, 4'b0100});

        // Async reset during ch0 repeat.
        i_buttons = 4'b0001;
        found = 1'b0;
        for (int i = 0; i < 15 && !found; i++) begin
            step();
            if (o_press[0]) found = 1'b1;
        end
        chk("ch0_repress", {15'd0, found}, 16'd1);
        found = 1'b0;
        for (int i = 0; i < 25 && !found; i++) begin
            step();
            if (o_step[0]) found = 1'b1;
        end
        chk("ch0_first_repeat", {15'd0, found}, 16'd1);
        repeat (3) step();
        chk("pre_reset_level", {15'd0, o_level[0]}, 16'd1);

        #2;
        i_rst = 1'b1;
        #1;
        chk("async_reset_now", {o_level, o_press, o_release, o_step}, 16'd0);
        repeat (2) step();
        chk("reset_held", {o_level, o_press, o_release, o_step}, 16'd0);

        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        cyc   = 0;
        for (int k = 1; k <= 13; k++) begin
            step();
            chk($sformatf("post_reset_press_k%0d", k), {15'd0, o_press[0]},
                {15'd0, (k == 12)});
            if (k == 12) chk("post_reset_outs", {o_level, o_step}, {4'b0001, 4'b0001});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
